sram_write_drain: RTL and testbench

- Downstream consumer of the 17-bit sram write FIFO in the sram peripheral.
- Pops one entry at a time and writes it to the external asynchronous 16-bit SRAM using a timed chip-select / write-enable sequence.
- Each entry is {sof, pixel[15:0]}. The block keeps a frame write address that auto-increments and wraps, so the image pipeline streams a frame into SRAM without supplying addresses.

---
 rtl/sram_write_drain.sv | 126 ++++++++++++
 tb/tb_sram_write_drain.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_write_drain.sv
// Drains the 17-bit {sof, pixel} write FIFO into an async 16-bit SRAM with a
// timed CE/WE sequence and an auto-incrementing, wrapping frame address.
module sram_write_drain #(
   parameter int unsigned ADDR_WIDTH   = 18,
   parameter int unsigned BASE_ADDR    = 0,
   parameter int unsigned FRAME_PIXELS = 76800,
   parameter int unsigned WRITE_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic [16:0]           fifo_data_out,
   output logic                  fifo_read_en,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [15:0]           sram_dq_out,
   output logic                  sram_dq_oe,
   output logic                  sram_ce_n,
   output logic                  sram_we_n,
   output logic                  sram_oe_n,
   output logic                  sram_ub_n,
   output logic                  sram_lb_n,
   output logic                  busy,
   output logic                  frame_done
);

   localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(BASE_ADDR + FRAME_PIXELS - 1);
   localparam logic [ADDR_WIDTH-1:0] ONE_A  = ADDR_WIDTH'(1);
   localparam logic [3:0]            WC_LAST = 4'(WRITE_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_POP, S_CAPTURE, S_SETUP, S_WRITE, S_HOLD
   } state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [15:0]           dq_q, dq_d;
   logic                  rd_en_q, dq_oe_q, ce_n_q, we_n_q, busy_q, fdone_q, fdone_d;
   logic                  active_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         wptr_q  <= BASE_A;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wptr_q  <= wptr_d;
      end
   end

   // sram_addr_q / dq_q double as the captured target and pixel registers.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wptr_d  = wptr_q;
      addr_d  = addr_q;
      dq_d    = dq_q;
      fdone_d = 1'b0;
      case (state_q)
         S_IDLE:    if (enable && !fifo_empty) state_d = S_POP;
         S_POP:     state_d = S_CAPTURE;
         S_CAPTURE: begin
            addr_d  = fifo_data_out[16] ? BASE_A : wptr_q;
            dq_d    = fifo_data_out[15:0];
            state_d = S_SETUP;
         end
         S_SETUP: begin
            cnt_d   = '0;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            if (cnt_q == WC_LAST) state_d = S_HOLD;
            else                  cnt_d   = cnt_q + 4'd1;
         end
         S_HOLD: begin
            wptr_d  = (addr_q == LAST_A) ? BASE_A : addr_q + ONE_A;
            fdone_d = (addr_q == LAST_A);
            state_d = (enable && !fifo_empty) ? S_POP : S_IDLE;
         end
         default:   state_d = S_IDLE;
      endcase
   end

   assign active_d = (state_d == S_SETUP) || (state_d == S_WRITE) || (state_d == S_HOLD);

   // Strobes are registered from the next state so each lines up with its state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_en_q <= 1'b0;
         addr_q  <= BASE_A;
         dq_q    <= '0;
         dq_oe_q <= 1'b0;
         ce_n_q  <= 1'b1;
         we_n_q  <= 1'b1;
         busy_q  <= 1'b0;
         fdone_q <= 1'b0;
      end else begin
         rd_en_q <= (state_d == S_POP);
         addr_q  <= addr_d;
         dq_q    <= dq_d;
         dq_oe_q <= active_d;
         ce_n_q  <= !active_d;
         we_n_q  <= (state_d != S_WRITE);
         busy_q  <= (state_d != S_IDLE);
         fdone_q <= fdone_d;
      end
   end

   assign fifo_read_en = rd_en_q;
   assign sram_addr    = addr_q;
   assign sram_dq_out  = dq_q;
   assign sram_dq_oe   = dq_oe_q;
   assign sram_ce_n    = ce_n_q;
   assign sram_we_n    = we_n_q;
   assign sram_oe_n    = 1'b1;
   assign sram_ub_n    = ce_n_q;
   assign sram_lb_n    = ce_n_q;
   assign busy         = busy_q;
   assign frame_done   = fdone_q;

endmodule

// File: tb/tb_sram_write_drain.sv
// Bench for sram_write_drain: FIFO model, bus monitor and an address-sequence
// reference model; small 4-word frame so wraps occur often.
module tb_sram_write_drain;
   localparam int AW   = 18;
   localparam int BASE = 0;
   localparam int FP   = 4;
   localparam int WC   = 2;
   localparam int LAST = BASE + FP - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enable = 1'b0;
   logic          fifo_empty;
   logic [16:0]   fifo_data_out = '0;
   logic          fifo_read_en;
   logic [AW-1:0] sram_addr;
   logic [15:0]   sram_dq_out;
   logic          sram_dq_oe, sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n;
   logic          busy, frame_done;

   sram_write_drain #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .FRAME_PIXELS(FP), .WRITE_CYCLES(WC)) dut (
      .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
      .fifo_data_out(fifo_data_out), .fifo_read_en(fifo_read_en),
      .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
      .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
      .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n), .busy(busy), .frame_done(frame_done));

   always #5 clk = ~clk;

   // FIFO model: bench writes wr_ptr, the pop process owns rd_ptr.
   logic [16:0] fmem [0:255];
   int wr_ptr = 0, rd_ptr = 0, underflow = 0;
   assign fifo_empty = (wr_ptr == rd_ptr);
   always @(posedge clk)
      if (fifo_read_en) begin
         if (wr_ptr == rd_ptr) underflow <= underflow + 1;
         else begin
            fifo_data_out <= fmem[rd_ptr % 256];
            rd_ptr <= rd_ptr + 1;
         end
      end

   // Bus monitor: one record per completed write pulse.
   typedef struct {int addr; int data; int len; int start; bit su_ok; bit hold_ok;} wr_t;
   wr_t wlog[$];
   int  pops[$], fds[$], busy_runs[$];
   int  cyc = 0, viol = 0, unstable = 0, dblpop = 0;
   initial begin : monitor
      wr_t cur;
      logic p_we, p_ce, p_oe, p_re, p_busy;
      logic [AW-1:0] p_addr;
      logic [15:0] p_data;
      int brun;
      p_we = 1; p_ce = 1; p_oe = 0; p_re = 0; p_busy = 0; p_addr = '0; p_data = '0; brun = 0;
      cur = '{0, 0, 0, 0, 0, 0};
      forever begin
         @(negedge clk);
         cyc = cyc + 1;
         if (fifo_read_en) pops.push_back(cyc);
         if (fifo_read_en && p_re) dblpop = dblpop + 1;
         if (frame_done) fds.push_back(cyc);
         if (busy) brun = brun + 1;
         else if (p_busy) begin busy_runs.push_back(brun); brun = 0; end
         if (sram_ub_n !== sram_ce_n || sram_lb_n !== sram_ce_n || sram_oe_n !== 1'b1) viol = viol + 1;
         if (!sram_we_n) begin
            if (sram_ce_n || !sram_dq_oe) viol = viol + 1;
            if (p_we) begin
               cur.addr = int'(sram_addr); cur.data = int'(sram_dq_out); cur.len = 0; cur.start = cyc;
               cur.su_ok = !p_ce && p_oe && p_addr == sram_addr && p_data == sram_dq_out;
            end else if (int'(sram_addr) != cur.addr || int'(sram_dq_out) != cur.data)
               unstable = unstable + 1;
            cur.len = cur.len + 1;
         end else if (!p_we) begin
            cur.hold_ok = !sram_ce_n && sram_dq_oe && int'(sram_addr) == cur.addr && int'(sram_dq_out) == cur.data;
            wlog.push_back(cur);
         end
         p_we = sram_we_n; p_ce = sram_ce_n; p_oe = sram_dq_oe; p_re = fifo_read_en;
         p_busy = busy; p_addr = sram_addr; p_data = sram_dq_out;
      end
   end

   // Reference model: the frame pointer as plain integer arithmetic.
   int ncmp = 0, nerr = 0;
   int mptr = BASE, efd = 0;
   int ea[$], ed[$];

   task automatic push(input bit sof, input logic [15:0] px);
      int a;
      fmem[wr_ptr % 256] = {sof, px};
      wr_ptr = wr_ptr + 1;
      a = sof ? BASE : mptr;
      ea.push_back(a); ed.push_back(int'(px));
      if (a == LAST) begin mptr = BASE; efd = efd + 1; end
      else mptr = a + 1;
   endtask

   task automatic wait_idle(input int maxc);
      int n = 0;
      do begin @(negedge clk); n++; end while (((!fifo_empty && enable) || busy) && n < maxc);
      repeat (2) @(negedge clk);
      if (n >= maxc) begin
         ncmp++; nerr++;
         $display("FAIL idle_timeout: still busy after %0d cycles, required idle", n);
      end
   endtask

   task automatic test_reset();
      rst = 1; enable = 0;
      repeat (3) @(negedge clk);
      ncmp++;
      if ({fifo_read_en, sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n, sram_dq_oe, busy, frame_done} !== 9'b011111000) begin
         nerr++; $display("FAIL reset_ctrl: got %b required 011111000",
            {fifo_read_en, sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n, sram_dq_oe, busy, frame_done});
      end
      ncmp++;
      if (sram_addr !== AW'(BASE) || sram_dq_out !== 16'h0) begin
         nerr++; $display("FAIL reset_bus: addr %0h data %0h required %0h/0", sram_addr, sram_dq_out, BASE);
      end
      rst = 0;
      repeat (3) @(negedge clk);
      ncmp++;
      if (busy !== 1'b0 || fifo_read_en !== 1'b0) begin
         nerr++; $display("FAIL reset_idle: busy %b rd %b required 0/0", busy, fifo_read_en);
      end
   endtask

   task automatic test_single();
      int i0 = wlog.size(), p0 = pops.size(), b0 = busy_runs.size();
      ea.delete(); ed.delete();
      enable = 1;
      push(1, 16'hABCD);
      wait_idle(50);
      ncmp++;
      if (pops.size() - p0 != 1 || wlog.size() - i0 != 1 || busy_runs.size() - b0 != 1) begin
         nerr++; $display("FAIL single_count: pops %0d writes %0d busy_runs %0d required 1/1/1",
            pops.size() - p0, wlog.size() - i0, busy_runs.size() - b0);
      end else begin
         ncmp++;
         if (wlog[i0].addr != 0 || wlog[i0].data != 'hABCD) begin
            nerr++; $display("FAIL single_write: addr %0h data %0h required 0/abcd", wlog[i0].addr, wlog[i0].data);
         end
         ncmp++;
         if (wlog[i0].len != WC || wlog[i0].start - pops[p0] != 3) begin
            nerr++; $display("FAIL single_timing: we_len %0d latency %0d required %0d/3",
               wlog[i0].len, wlog[i0].start - pops[p0], WC);
         end
         ncmp++;
         if (!wlog[i0].su_ok || !wlog[i0].hold_ok || busy_runs[b0] != WC + 4) begin
            nerr++; $display("FAIL single_setup_hold: su %0b hold %0b busy_len %0d required 1/1/%0d",
               wlog[i0].su_ok, wlog[i0].hold_ok, busy_runs[b0], WC + 4);
         end
      end
      push(0, 16'h1111);
      wait_idle(50);
      ncmp++;
      if (wlog.size() - i0 != 2 || wlog[wlog.size() - 1].addr != 1) begin
         nerr++; $display("FAIL single_ptr: writes %0d last addr %0d required 2/1",
            wlog.size() - i0, wlog.size() > 0 ? wlog[wlog.size() - 1].addr : -1);
      end
   endtask

   task automatic test_back_to_back();
      int i0 = wlog.size(), p0 = pops.size(), b0 = busy_runs.size();
      ea.delete(); ed.delete();
      push(1, 16'h0001); push(0, 16'h0002); push(0, 16'h0003);
      wait_idle(80);
      ncmp++;
      if (wlog.size() - i0 != 3 || pops.size() - p0 != 3 || busy_runs.size() - b0 != 1) begin
         nerr++; $display("FAIL b2b_count: writes %0d pops %0d busy_runs %0d required 3/3/1",
            wlog.size() - i0, pops.size() - p0, busy_runs.size() - b0);
      end else begin
         for (int k = 0; k < 3; k++) begin
            ncmp++;
            if (wlog[i0+k].addr != ea[k] || wlog[i0+k].data != ed[k] || wlog[i0+k].addr != k) begin
               nerr++; $display("FAIL b2b_write%0d: addr %0d data %0h required %0d/%0h", k,
                  wlog[i0+k].addr, wlog[i0+k].data, ea[k], ed[k]);
            end
         end
         ncmp++;
         if (pops[p0+1] - pops[p0] != WC + 4 || pops[p0+2] - pops[p0+1] != WC + 4) begin
            nerr++; $display("FAIL b2b_spacing: %0d,%0d required %0d", pops[p0+1] - pops[p0],
               pops[p0+2] - pops[p0+1], WC + 4);
         end
         ncmp++;
         if (busy_runs[b0] != 3 * (WC + 4)) begin
            nerr++; $display("FAIL b2b_busy: busy run %0d required %0d", busy_runs[b0], 3 * (WC + 4));
         end
      end
   endtask

   task automatic test_wrap();
      int i0 = wlog.size(), f0 = fds.size();
      ea.delete(); ed.delete(); efd = 0;
      push(1, 16'h1000);
      for (int k = 1; k < 5; k++) push(0, 16'(16'h1000 + k));
      wait_idle(100);
      ncmp++;
      if (wlog.size() - i0 != 5) begin
         nerr++; $display("FAIL wrap_count: writes %0d required 5", wlog.size() - i0);
      end else begin
         for (int k = 0; k < 5; k++) begin
            ncmp++;
            if (wlog[i0+k].addr != ea[k] || wlog[i0+k].data != ed[k]) begin
               nerr++; $display("FAIL wrap_write%0d: addr %0d data %0h required %0d/%0h", k,
                  wlog[i0+k].addr, wlog[i0+k].data, ea[k], ed[k]);
            end
         end
         ncmp++;
         if (fds.size() - f0 != 1 || efd != 1) begin
            nerr++; $display("FAIL wrap_fd_count: pulses %0d required %0d", fds.size() - f0, efd);
         end else begin
            ncmp++;
            if (fds[f0] != wlog[i0+3].start + WC + 1) begin
               nerr++; $display("FAIL wrap_fd_time: cycle %0d required %0d", fds[f0], wlog[i0+3].start + WC + 1);
            end
         end
      end
   endtask

   task automatic test_enable_drop();
      int i0 = wlog.size(), p0 = pops.size(), n = 0;
      ea.delete(); ed.delete();
      push(1, 16'h2000); push(0, 16'h2001); push(0, 16'h2002);
      while (sram_we_n && n < 30) begin @(negedge clk); n++; end
      if (n >= 30) begin
         ncmp++; nerr++; $display("FAIL drop_wait: sram_we_n stayed high for %0d cycles, required a write", n);
      end
      enable = 0;
      repeat (30) @(negedge clk);
      ncmp++;
      if (pops.size() - p0 != 1 || wlog.size() - i0 != 1 || busy !== 1'b0) begin
         nerr++; $display("FAIL drop_hold: pops %0d writes %0d busy %b required 1/1/0",
            pops.size() - p0, wlog.size() - i0, busy);
      end
      enable = 1;
      wait_idle(80);
      ncmp++;
      if (wlog.size() - i0 != 3) begin
         nerr++; $display("FAIL drop_count: writes %0d required 3", wlog.size() - i0);
      end else begin
         for (int k = 0; k < 3; k++) begin
            ncmp++;
            if (wlog[i0+k].addr != ea[k] || wlog[i0+k].data != ed[k]) begin
               nerr++; $display("FAIL drop_write%0d: addr %0d data %0h required %0d/%0h", k,
                  wlog[i0+k].addr, wlog[i0+k].data, ea[k], ed[k]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int i0, n = 0;
      ea.delete(); ed.delete();
      push(0, 16'h7777);
      while (sram_we_n && n < 30) begin @(negedge clk); n++; end
      if (n >= 30) begin
         ncmp++; nerr++; $display("FAIL rstmid_wait: sram_we_n stayed high for %0d cycles, required a write", n);
      end
      #2 rst = 1;
      #1;
      ncmp++;
      if ({sram_we_n, sram_ce_n, sram_dq_oe, busy} !== 4'b1100) begin
         nerr++; $display("FAIL rstmid_async: we/ce/oe/busy %b required 1100", {sram_we_n, sram_ce_n, sram_dq_oe, busy});
      end
      @(negedge clk); @(negedge clk);
      rst = 0;
      @(negedge clk);
      ea.delete(); ed.delete(); mptr = BASE;
      i0 = wlog.size();
      push(0, 16'h5555);
      wait_idle(50);
      ncmp++;
      if (wlog.size() - i0 != 1 || wlog[wlog.size() - 1].addr != BASE || wlog[wlog.size() - 1].data != 'h5555) begin
         nerr++; $display("FAIL rstmid_next: writes %0d addr %0d required 1/%0d",
            wlog.size() - i0, wlog.size() > 0 ? wlog[wlog.size() - 1].addr : -1, BASE);
      end
   endtask

   task automatic test_empty();
      int nre = 0, nb = 0;
      enable = 1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (fifo_read_en) nre++;
         if (busy) nb++;
      end
      ncmp++;
      if (nre != 0 || nb != 0) begin
         nerr++; $display("FAIL empty_idle: pops %0d busy cycles %0d required 0/0", nre, nb);
      end
   endtask

   task automatic test_random();
      int i0 = wlog.size(), f0 = fds.size(), bad = 0;
      ea.delete(); ed.delete(); efd = 0;
      for (int k = 0; k < 40; k++) begin
         push(($urandom_range(0, 7) == 0) || k == 0, 16'($urandom));
         repeat ($urandom_range(0, 8)) begin
            @(negedge clk);
            enable = ($urandom_range(0, 3) != 0);
         end
      end
      enable = 1;
      wait_idle(2000);
      ncmp++;
      if (wlog.size() - i0 != 40) begin
         nerr++; $display("FAIL rand_count: writes %0d required 40", wlog.size() - i0);
      end else begin
         for (int k = 0; k < 40; k++)
            if (wlog[i0+k].addr != ea[k] || wlog[i0+k].data != ed[k] || wlog[i0+k].len != WC
                || !wlog[i0+k].su_ok || !wlog[i0+k].hold_ok) bad++;
         ncmp++;
         if (bad != 0) begin
            nerr++; $display("FAIL rand_writes: %0d bad writes required 0", bad);
         end
      end
      ncmp++;
      if (fds.size() - f0 != efd) begin
         nerr++; $display("FAIL rand_frame_done: pulses %0d required %0d", fds.size() - f0, efd);
      end
      ncmp++;
      if (viol != 0 || unstable != 0 || dblpop != 0 || underflow != 0) begin
         nerr++; $display("FAIL bus_rules: viol %0d unstable %0d dblpop %0d underflow %0d required 0",
            viol, unstable, dblpop, underflow);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_wrap();
      test_enable_drop();
      test_reset_mid();
      test_empty();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
